// File: rtl/lsu_access.sv
// lsu_access: data-memory access and writeback formation for the rv32i pipeline.
//
// Takes the memory-stage bundle, runs loads/stores against data memory over a
// req/ack handshake, and presents one registered writeback per retired op.
// Non-memory ops retire the next cycle. Memory ops take one accept cycle,
// then wait in REQ until mem_ack, then spend one cycle in DONE.
//
// Optional build macro: LSU_TIMEOUT_EN
//   When defined, a REQ that sees no mem_ack for TIMEOUT_CYCLES cycles is
//   abandoned: mem_req drops and an err/wb_valid (wb_we=0) pulse is issued.
//   When undefined, REQ waits for mem_ack indefinitely.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   in_valid        bundle valid this cycle
//   is_load/is_store/reg_we/rs2/alu_result/rd_src/alucode  memory-stage bundle
//   stall           upstream must hold the bundle (combinational)
//   mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata  data-memory request (registered)
//   mem_ack/mem_rdata  request completion and read data
//   wb_valid/wb_we/wb_rd/wb_data  writeback slot (registered)
//   err             one-cycle pulse on misaligned access or timeout
//
// alucode values (match define.vh):
//   ALU_LB=20 ALU_LH=21 ALU_LW=22 ALU_LBU=23 ALU_LHU=24 ALU_SB=25 ALU_SH=26 ALU_SW=27

module lsu_access #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_we,
    input  logic [31:0] rs2,
    input  logic [31:0] alu_result,
    input  logic [4:0]  rd_src,
    input  logic [5:0]  alucode,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LBU = 6'd23;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // A zero timeout would abort every request before it could complete.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("lsu_access: TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state_q, state_d;

    // Bundle fields needed after the accept cycle.
    logic        ld_q, ld_d;
    logic        reg_we_q, reg_we_d;
    logic [4:0]  rd_q, rd_d;
    logic [5:0]  code_q, code_d;
    logic [1:0]  off_q, off_d;

    logic        mem_req_d, mem_we_d;
    logic [31:0] mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_wstrb_d;
    logic        wb_valid_d, wb_we_d, err_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;

    logic        is_mem;
    logic        size_w, size_h;
    logic        misaligned;
    logic [31:0] lane;
    logic [31:0] load_val;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                    $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Access size and alignment of the incoming bundle.
    always_comb begin
        is_mem     = is_load | is_store;
        size_w     = (alucode == ALU_LW) || (alucode == ALU_SW);
        size_h     = (alucode == ALU_LH) || (alucode == ALU_LHU) || (alucode == ALU_SH);
        misaligned = (size_w && (alu_result[1:0] != 2'b00)) ||
                     (size_h && alu_result[0]);
    end

    // Load extraction from the returned word, using the captured offset.
    always_comb begin
        lane     = mem_rdata >> {off_q, 3'b000};
        load_val = mem_rdata;
        case (code_q)
            ALU_LB:  load_val = {{24{lane[7]}}, lane[7:0]};
            ALU_LBU: load_val = {24'd0, lane[7:0]};
            ALU_LH:  load_val = {{16{lane[15]}}, lane[15:0]};
            ALU_LHU: load_val = {16'd0, lane[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d     = state_q;
        ld_d        = ld_q;
        reg_we_d    = reg_we_q;
        rd_d        = rd_q;
        code_d      = code_q;
        off_d       = off_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = 32'd0;
        mem_wstrb_d = 4'd0;
        mem_wdata_d = 32'd0;
        wb_valid_d  = 1'b0;
        wb_we_d     = 1'b0;
        wb_rd_d     = 5'd0;
        wb_data_d   = 32'd0;
        err_d       = 1'b0;
        stall       = 1'b0;
`ifdef LSU_TIMEOUT_EN
        cnt_d       = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (in_valid && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_we_d    = reg_we;
                    wb_rd_d    = reg_we ? rd_src : 5'd0;
                    wb_data_d  = alu_result;
                end else if (in_valid && misaligned) begin
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
                end else if (in_valid) begin
                    stall      = rst;
                    state_d    = S_REQ;
                    ld_d       = is_load;
                    reg_we_d   = reg_we;
                    rd_d       = rd_src;
                    code_d     = alucode;
                    off_d      = alu_result[1:0];
                    mem_req_d  = 1'b1;
                    mem_we_d   = is_store & ~is_load;
                    mem_addr_d = {alu_result[31:2], 2'b00};
                    if (is_store && !is_load) begin
                        case (alucode)
                            ALU_SB: begin
                                mem_wstrb_d = 4'b0001 << alu_result[1:0];
                                mem_wdata_d = {4{rs2[7:0]}};
                            end
                            ALU_SH: begin
                                mem_wstrb_d = alu_result[1] ? 4'b1100 : 4'b0011;
                                mem_wdata_d = {2{rs2[15:0]}};
                            end
                            default: begin
                                mem_wstrb_d = 4'b1111;
                                mem_wdata_d = rs2;
                            end
                        endcase
                    end
                end
            end

            S_REQ: begin
                stall = rst;
                if (mem_ack) begin
                    state_d    = S_DONE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = ld_q & reg_we_q;
                    wb_rd_d    = (ld_q & reg_we_q) ? rd_q : 5'd0;
                    wb_data_d  = ld_q ? load_val : 32'd0;
`ifdef LSU_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_IDLE;
                    wb_valid_d = 1'b1;
                    err_d      = 1'b1;
`endif
                end else begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = mem_we;
                    mem_addr_d  = mem_addr;
                    mem_wstrb_d = mem_wstrb;
                    mem_wdata_d = mem_wdata;
`ifdef LSU_TIMEOUT_EN
                    cnt_d       = cnt_q + CNT_W'(1);
`endif
                end
            end

            // Upstream still shows the retiring bundle here; it is not re-accepted.
            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            ld_q      <= 1'b0;
            reg_we_q  <= 1'b0;
            rd_q      <= 5'd0;
            code_q    <= 6'd0;
            off_q     <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wstrb <= 4'd0;
            mem_wdata <= 32'd0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= 5'd0;
            wb_data   <= 32'd0;
            err       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ld_q      <= ld_d;
            reg_we_q  <= reg_we_d;
            rd_q      <= rd_d;
            code_q    <= code_d;
            off_q     <= off_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wstrb <= mem_wstrb_d;
            mem_wdata <= mem_wdata_d;
            wb_valid  <= wb_valid_d;
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            err       <= err_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_lsu_access.sv
// Directed testbench for lsu_access. Inputs change 1ns after posedge;
// outputs are checked in that same settled window.

module tb_lsu_access;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    localparam logic [5:0] ALU_ADD = 6'd0;
    localparam logic [5:0] ALU_LB  = 6'd20;
    localparam logic [5:0] ALU_LH  = 6'd21;
    localparam logic [5:0] ALU_LW  = 6'd22;
    localparam logic [5:0] ALU_LHU = 6'd24;
    localparam logic [5:0] ALU_SB  = 6'd25;
    localparam logic [5:0] ALU_SH  = 6'd26;
    localparam logic [5:0] ALU_SW  = 6'd27;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, is_load, is_store, reg_we;
    logic [31:0] rs2, alu_result;
    logic [4:0]  rd_src;
    logic [5:0]  alucode;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lsu_access #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .is_load(is_load),
        .is_store(is_store), .reg_we(reg_we), .rs2(rs2), .alu_result(alu_result),
        .rd_src(rd_src), .alucode(alucode), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic v, input logic ld, input logic st, input logic we,
                          input logic [31:0] d, input logic [31:0] a,
                          input logic [4:0] rd, input logic [5:0] code);
        in_valid = v; is_load = ld; is_store = st; reg_we = we;
        rs2 = d; alu_result = a; rd_src = rd; alucode = code;
    endtask

    task automatic idle_bundle();
        bundle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, ALU_ADD);
    endtask

    // Load issued at addr, acked in first REQ cycle with rdata; checks writeback.
    task automatic do_load(input string tag, input logic [5:0] code, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [4:0] rd,
                           input logic [31:0] exp);
        bundle(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, a, rd, code);
        #1 chk({tag, "_stall_acc"}, 32'(stall), 32'd1);
        tick();
        chk({tag, "_req"},   32'(mem_req),   32'd1);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
        chk({tag, "_addr"},  mem_addr,       {a[31:2], 2'b00});
        mem_ack = 1'b1; mem_rdata = rdata;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk({tag, "_wbv"},   32'(wb_valid), 32'd1);
        chk({tag, "_wbwe"},  32'(wb_we),    32'd1);
        chk({tag, "_wbrd"},  32'(wb_rd),    32'(rd));
        chk({tag, "_data"},  wb_data,       exp);
        chk({tag, "_reqlo"}, 32'(mem_req),  32'd0);
        chk({tag, "_stall"}, 32'(stall),    32'd0);
        tick();
        idle_bundle();
        chk({tag, "_wbv_off"}, 32'(wb_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        idle_bundle();
        tick(); tick();

        // Reset state
        chk("rst_req",   32'(mem_req),  32'd0);
        chk("rst_wbv",   32'(wb_valid), 32'd0);
        chk("rst_err",   32'(err),      32'd0);
        chk("rst_stall", 32'(stall),    32'd0);
        chk("rst_addr",  mem_addr,      32'd0);
        rst = 1'b1;
        tick();

        // Non-memory op retires next cycle
        bundle(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'h1234, 5'd5, ALU_ADD);
        #1 chk("alu_stall", 32'(stall), 32'd0);
        tick();
        idle_bundle();
        chk("alu_wbv",  32'(wb_valid), 32'd1);
        chk("alu_wbwe", 32'(wb_we),    32'd1);
        chk("alu_wbrd", 32'(wb_rd),    32'd5);
        chk("alu_data", wb_data,       32'h1234);
        chk("alu_req",  32'(mem_req),  32'd0);
        tick();
        chk("alu_wbv_off", 32'(wb_valid), 32'd0);

        // Non-memory op with reg_we=0: wb_rd forced to 0
        bundle(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'h55, 5'd9, ALU_ADD);
        tick();
        idle_bundle();
        chk("nowe_wbv",  32'(wb_valid), 32'd1);
        chk("nowe_wbwe", 32'(wb_we),    32'd0);
        chk("nowe_wbrd", 32'(wb_rd),    32'd0);

        // SB at 0x103, ack in third REQ cycle
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'hAABBCCDD, 32'h103, 5'd0, ALU_SB);
        #1 chk("sb_stall_acc", 32'(stall), 32'd1);
        chk("sb_req_acc", 32'(mem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sb_req",   32'(mem_req),   32'd1);
            chk("sb_stall", 32'(stall),     32'd1);
            chk("sb_addr",  mem_addr,       32'h100);
            chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
            chk("sb_wdata", mem_wdata,      32'hDDDDDDDD);
            chk("sb_we",    32'(mem_we),    32'd1);
            chk("sb_wbv",   32'(wb_valid),  32'd0);
        end
        mem_ack = 1'b1;
        #1 chk("sb_stall_ack", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        chk("sb_done_wbv",   32'(wb_valid), 32'd1);
        chk("sb_done_wbwe",  32'(wb_we),    32'd0);
        chk("sb_done_wbrd",  32'(wb_rd),    32'd0);
        chk("sb_done_req",   32'(mem_req),  32'd0);
        chk("sb_done_stall", 32'(stall),    32'd0);
        tick();
        idle_bundle();
        chk("sb_after_wbv", 32'(wb_valid), 32'd0);
        chk("sb_after_req", 32'(mem_req),  32'd0);

        // SH at 0x106, ack in first REQ cycle
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'h1234ABCD, 32'h106, 5'd0, ALU_SH);
        tick();
        chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
        chk("sh_wdata", mem_wdata,      32'hABCDABCD);
        chk("sh_addr",  mem_addr,       32'h104);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sh_wbv", 32'(wb_valid), 32'd1);
        tick();
        idle_bundle();

        // SW at 0x20
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D, 32'h20, 5'd0, ALU_SW);
        tick();
        chk("sw_wstrb", 32'(mem_wstrb), 32'hF);
        chk("sw_wdata", mem_wdata,      32'hCAFEF00D);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
        idle_bundle();

        // Loads: sign/zero extension and lane selection
        do_load("lb",  ALU_LB,  32'h202, 32'h0080FF00, 5'd7,  32'hFFFFFF80);
        do_load("lhu", ALU_LHU, 32'h202, 32'h0080FF00, 5'd8,  32'h00000080);
        do_load("lh",  ALU_LH,  32'h200, 32'h00008001, 5'd9,  32'hFFFF8001);
        do_load("lw",  ALU_LW,  32'h204, 32'h12345678, 5'd10, 32'h12345678);

        // Misaligned LW at 0x6
        bundle(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'h6, 5'd3, ALU_LW);
        #1 chk("mis_stall", 32'(stall), 32'd0);
        tick();
        idle_bundle();
        chk("mis_req",  32'(mem_req),  32'd0);
        chk("mis_err",  32'(err),      32'd1);
        chk("mis_wbv",  32'(wb_valid), 32'd1);
        chk("mis_wbwe", 32'(wb_we),    32'd0);
        chk("mis_wbrd", 32'(wb_rd),    32'd0);
        tick();
        chk("mis_err_off", 32'(err),     32'd0);
        chk("mis_req_off", 32'(mem_req), 32'd0);

        // Misaligned LH at 0x201
        bundle(1'b1, 1'b1, 1'b0, 1'b1, 32'd0, 32'h201, 5'd3, ALU_LH);
        tick();
        idle_bundle();
        chk("mish_err", 32'(err),     32'd1);
        chk("mish_req", 32'(mem_req), 32'd0);
        tick();

        // mem_ack in IDLE is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        chk("stray_wbv", 32'(wb_valid), 32'd0);
        chk("stray_req", 32'(mem_req),  32'd0);

        // Reset mid-REQ abandons the transaction
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'h11112222, 32'h300, 5'd0, ALU_SW);
        tick();
        chk("rmid_req", 32'(mem_req), 32'd1);
        rst = 1'b0;
        tick();
        chk("rmid_req0",   32'(mem_req),   32'd0);
        chk("rmid_wbv",    32'(wb_valid),  32'd0);
        chk("rmid_addr",   mem_addr,       32'd0);
        chk("rmid_wstrb",  32'(mem_wstrb), 32'd0);
        chk("rmid_stall",  32'(stall),     32'd0);
        rst = 1'b1;
        idle_bundle();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rmid_post_wbv", 32'(wb_valid), 32'd0);
        chk("rmid_post_req", 32'(mem_req),  32'd0);

`ifdef LSU_TIMEOUT_EN
        // No ack: request abandoned after 4 REQ cycles
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 5'd0, ALU_SW);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("to_req",   32'(mem_req), 32'd1);
            chk("to_stall", 32'(stall),   32'd1);
        end
        tick();
        idle_bundle();
        chk("to_req0",  32'(mem_req),  32'd0);
        chk("to_err",   32'(err),      32'd1);
        chk("to_wbv",   32'(wb_valid), 32'd1);
        chk("to_wbwe",  32'(wb_we),    32'd0);
        #1 chk("to_stall0", 32'(stall), 32'd0);
        tick();
        chk("to_err_off", 32'(err), 32'd0);
`else
        // Without timeout, REQ holds for a long wait and then completes
        bundle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 5'd0, ALU_SW);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wait_req", 32'(mem_req), 32'd1);
            chk("wait_err", 32'(err),     32'd0);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("wait_wbv", 32'(wb_valid), 32'd1);
        chk("wait_req0", 32'(mem_req), 32'd0);
        tick();
        idle_bundle();
`endif

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
